// File: rtl/fdiv_poly_if.sv
// fdiv_poly_if: bus bundle for the fdiv_poly multi-channel tone divider.
//   divn     : NCH*W divisor bus, channel i uses divn[i*W +: W]
//   div_load : per-channel strobe capturing that channel's divisor slice
//   mute     : per-channel output mute (counter keeps running)
//   fout     : per-channel registered square-wave output
//   tick     : per-channel one-cycle pulse at each period wrap
//   nactive  : number of fout bits currently high
// master drives the controls; slave is the divider itself.
interface fdiv_poly_if #(
    parameter int NCH = 4,
    parameter int W   = 32
);
    localparam int NW = $clog2(NCH + 1);

    logic [NCH*W-1:0] divn;
    logic [NCH-1:0]   div_load;
    logic [NCH-1:0]   mute;
    logic [NCH-1:0]   fout;
    logic [NCH-1:0]   tick;
    logic [NW-1:0]    nactive;

    modport master (
        output divn, div_load, mute,
        input  fout, tick, nactive
    );

    modport slave (
        input  divn, div_load, mute,
        output fout, tick, nactive
    );
endinterface

// File: rtl/fdiv_poly.sv
// fdiv_poly: NCH independent programmable clock dividers (tone generators).
//   fin   : sole clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : fdiv_poly_if.slave (divn, div_load, mute -> fout, tick, nactive)
// A channel with active divisor act >= 2 counts cnt = 1..act and produces a
// square wave of period act (low floor(act/2) cycles, then high). A newly
// loaded divisor waits in pend and is only adopted at a period boundary, or
// immediately when the channel is idle (act < 2).
module fdiv_poly #(
    parameter int NCH = 4,
    parameter int W   = 32
) (
    input logic       fin,
    input logic       reset,
    fdiv_poly_if.slave bus
);
    localparam int NW = $clog2(NCH + 1);

    logic [W-1:0]   cnt  [NCH];
    logic [W-1:0]   act  [NCH];
    logic [W-1:0]   pend [NCH];
    logic [NCH-1:0] pv;
    logic [NCH-1:0] fout_q;
    logic [NCH-1:0] tick_q;

    logic [NCH-1:0] running;
    logic [NCH-1:0] wrap;
    logic [NCH-1:0] apply;

    always_comb begin
        running = '0;
        wrap    = '0;
        apply   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            running[i] = (act[i] >= W'(2));
            wrap[i]    = running[i] && (cnt[i] >= act[i]);
            // pending divisor is adopted at a boundary or straight away when idle
            apply[i]   = pv[i] && (wrap[i] || !running[i]);
        end
    end

    always_ff @(posedge fin) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i]  <= W'(1);
                act[i]  <= '0;
                pend[i] <= '0;
            end
            pv     <= '0;
            fout_q <= '0;
            tick_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!running[i] || wrap[i]) begin
                    cnt[i] <= W'(1);
                end else begin
                    cnt[i] <= cnt[i] + W'(1);
                end

                if (apply[i]) begin
                    act[i] <= pend[i];
                    pv[i]  <= 1'b0;
                end

                // a load coincident with a boundary lands in pend for the next one
                if (bus.div_load[i]) begin
                    pend[i] <= bus.divn[i*W +: W];
                    pv[i]   <= 1'b1;
                end

                fout_q[i] <= running[i] && (cnt[i] > (act[i] >> 1)) && !bus.mute[i];
                tick_q[i] <= wrap[i];
            end
        end
    end

    always_comb begin
        bus.nactive = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            bus.nactive = bus.nactive + NW'(fout_q[i]);
        end
    end

    assign bus.fout = fout_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_fdiv_poly.sv
// tb_fdiv_poly: directed self-checking bench for fdiv_poly (NCH=4, W=32).
// Sample index p counts cycles within a period, p=0 being the first output
// after the counter starts at 1; fout is high for p >= d/2, tick at p = d-1.
module tb_fdiv_poly;
    localparam int NCH = 4;
    localparam int W   = 32;

    logic fin;
    logic reset;
    int   checks;
    int   failures;

    fdiv_poly_if #(.NCH(NCH), .W(W)) dif ();

    fdiv_poly #(.NCH(NCH), .W(W)) dut (
        .fin   (fin),
        .reset (reset),
        .bus   (dif)
    );

    initial fin = 1'b0;
    always #5 fin = ~fin;

    function automatic logic ef(input int d, input int p);
        return (p >= d / 2);
    endfunction

    function automatic logic et(input int d, input int p);
        return (p == d - 1);
    endfunction

    // One clock edge; loads are single-cycle strobes.
    task automatic step();
        @(posedge fin);
        #1;
        dif.div_load = '0;
    endtask

    task automatic load(input int ch, input int val);
        dif.divn[ch*W +: W] = val;
        dif.div_load[ch]    = 1'b1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        dif.mute = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    // After this, the next step() yields phase 0 of channel 0.
    task automatic start_ch0(input int d);
        load(0, d);
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load(0, 4);
        load(1, 5);
        step();
        if (dif.fout !== 4'b0000) begin
            failures++;
            $display("FAIL reset_fout got=%b exp=%b", dif.fout, 4'b0000);
        end
        checks++;
        if (dif.tick !== 4'b0000) begin
            failures++;
            $display("FAIL reset_tick got=%b exp=%b", dif.tick, 4'b0000);
        end
        checks++;
        if (dif.nactive !== 3'd0) begin
            failures++;
            $display("FAIL reset_nactive got=%0d exp=0", dif.nactive);
        end
        checks++;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (dif.fout !== 4'b0000 || dif.tick !== 4'b0000) begin
                failures++;
                $display("FAIL reset_load_discard k=%0d fout=%b tick=%b exp=0000/0000", k, dif.fout, dif.tick);
            end
            checks++;
        end
    endtask

    task automatic test_div4();
        do_reset();
        start_ch0(4);
        if (dif.fout[0] !== 1'b0 || dif.tick[0] !== 1'b0) begin
            failures++;
            $display("FAIL div4_startup fout=%b tick=%b exp=0/0", dif.fout[0], dif.tick[0]);
        end
        checks++;
        for (int k = 0; k < 12; k++) begin
            step();
            if (dif.fout[0] !== ef(4, k % 4)) begin
                failures++;
                $display("FAIL div4_fout k=%0d got=%b exp=%b", k, dif.fout[0], ef(4, k % 4));
            end
            checks++;
            if (dif.tick[0] !== et(4, k % 4)) begin
                failures++;
                $display("FAIL div4_tick k=%0d got=%b exp=%b", k, dif.tick[0], et(4, k % 4));
            end
            checks++;
            if (dif.nactive !== 3'(ef(4, k % 4))) begin
                failures++;
                $display("FAIL div4_nactive k=%0d got=%0d exp=%0d", k, dif.nactive, ef(4, k % 4));
            end
            checks++;
        end
    endtask

    task automatic test_two_channels();
        logic e0, e1;
        do_reset();
        start_ch0(4);
        load(1, 5);
        for (int c = 0; c < 24; c++) begin
            step();
            e0 = ef(4, c % 4);
            e1 = (c >= 2) ? ef(5, (c - 2) % 5) : 1'b0;
            if (dif.fout[1:0] !== {e1, e0}) begin
                failures++;
                $display("FAIL two_ch_fout c=%0d got=%b exp=%b", c, dif.fout[1:0], {e1, e0});
            end
            checks++;
            if (dif.tick[1] !== ((c >= 2) ? et(5, (c - 2) % 5) : 1'b0)) begin
                failures++;
                $display("FAIL two_ch_tick1 c=%0d got=%b", c, dif.tick[1]);
            end
            checks++;
            if (dif.nactive !== 3'(int'(e0) + int'(e1))) begin
                failures++;
                $display("FAIL two_ch_nactive c=%0d got=%0d exp=%0d", c, dif.nactive, int'(e0) + int'(e1));
            end
            checks++;
        end
    endtask

    task automatic test_change();
        do_reset();
        start_ch0(4);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) load(0, 8);
            step();
            if (dif.fout[0] !== ef(4, k) || dif.tick[0] !== et(4, k)) begin
                failures++;
                $display("FAIL change_p4 k=%0d fout=%b tick=%b exp=%b/%b", k, dif.fout[0], dif.tick[0], ef(4, k), et(4, k));
            end
            checks++;
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 1) load(0, 6);
            if (k == 3) load(0, 10);
            step();
            if (dif.fout[0] !== ef(8, k) || dif.tick[0] !== et(8, k)) begin
                failures++;
                $display("FAIL change_p8 k=%0d fout=%b tick=%b exp=%b/%b", k, dif.fout[0], dif.tick[0], ef(8, k), et(8, k));
            end
            checks++;
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (dif.fout[0] !== ef(10, k) || dif.tick[0] !== et(10, k)) begin
                failures++;
                $display("FAIL change_p10 k=%0d fout=%b tick=%b exp=%b/%b", k, dif.fout[0], dif.tick[0], ef(10, k), et(10, k));
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_ch0(4);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) load(0, 6);
            if (k == 3) load(0, 12);
            step();
            if (dif.fout[0] !== ef(4, k) || dif.tick[0] !== et(4, k)) begin
                failures++;
                $display("FAIL coinc_p4 k=%0d fout=%b tick=%b exp=%b/%b", k, dif.fout[0], dif.tick[0], ef(4, k), et(4, k));
            end
            checks++;
        end
        for (int k = 0; k < 6; k++) begin
            step();
            if (dif.fout[0] !== ef(6, k) || dif.tick[0] !== et(6, k)) begin
                failures++;
                $display("FAIL coinc_p6 k=%0d fout=%b tick=%b exp=%b/%b", k, dif.fout[0], dif.tick[0], ef(6, k), et(6, k));
            end
            checks++;
        end
        for (int k = 0; k < 24; k++) begin
            step();
            if (dif.fout[0] !== ef(12, k % 12) || dif.tick[0] !== et(12, k % 12)) begin
                failures++;
                $display("FAIL coinc_p12 k=%0d fout=%b tick=%b exp=%b/%b", k, dif.fout[0], dif.tick[0], ef(12, k % 12), et(12, k % 12));
            end
            checks++;
        end
    endtask

    task automatic test_mute();
        logic ex;
        do_reset();
        start_ch0(8);
        for (int k = 0; k < 16; k++) begin
            dif.mute[0] = (k >= 4 && k <= 6);
            step();
            ex = ef(8, k % 8) && !(k >= 4 && k <= 6);
            if (dif.fout[0] !== ex) begin
                failures++;
                $display("FAIL mute_fout k=%0d got=%b exp=%b", k, dif.fout[0], ex);
            end
            checks++;
            if (dif.tick[0] !== et(8, k % 8)) begin
                failures++;
                $display("FAIL mute_tick k=%0d got=%b exp=%b", k, dif.tick[0], et(8, k % 8));
            end
            checks++;
        end
        dif.mute = '0;
    endtask

    task automatic test_all_channels();
        int d [NCH];
        logic [NCH-1:0] ef_v, et_v;
        int n;
        d[0] = 2; d[1] = 3; d[2] = 4; d[3] = 7;
        do_reset();
        for (int c = 0; c < NCH; c++) load(c, d[c]);
        step();
        step();
        for (int k = 0; k < 28; k++) begin
            step();
            n = 0;
            for (int c = 0; c < NCH; c++) begin
                ef_v[c] = ef(d[c], k % d[c]);
                et_v[c] = et(d[c], k % d[c]);
                n += int'(ef_v[c]);
            end
            if (dif.fout !== ef_v || dif.tick !== et_v) begin
                failures++;
                $display("FAIL all_ch k=%0d fout=%b tick=%b exp=%b/%b", k, dif.fout, dif.tick, ef_v, et_v);
            end
            checks++;
            if (dif.nactive !== 3'(n)) begin
                failures++;
                $display("FAIL all_ch_nactive k=%0d got=%0d exp=%0d", k, dif.nactive, n);
            end
            checks++;
        end
    endtask

    task automatic test_idle_and_reset();
        do_reset();
        load(0, 1);
        load(1, 0);
        load(2, 1);
        step();
        for (int k = 0; k < 12; k++) begin
            step();
            if (dif.fout !== 4'b0000 || dif.tick !== 4'b0000 || dif.nactive !== 3'd0) begin
                failures++;
                $display("FAIL idle_div k=%0d fout=%b tick=%b nactive=%0d exp=0000/0000/0", k, dif.fout, dif.tick, dif.nactive);
            end
            checks++;
        end
        do_reset();
        start_ch0(8);
        for (int k = 0; k < 6; k++) begin
            step();
            if (dif.fout[0] !== ef(8, k)) begin
                failures++;
                $display("FAIL pre_reset k=%0d got=%b exp=%b", k, dif.fout[0], ef(8, k));
            end
            checks++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        if (dif.fout !== 4'b0000 || dif.tick !== 4'b0000 || dif.nactive !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset fout=%b tick=%b nactive=%0d exp=0000/0000/0", dif.fout, dif.tick, dif.nactive);
        end
        checks++;
        for (int k = 0; k < 12; k++) begin
            step();
            if (dif.fout !== 4'b0000 || dif.tick !== 4'b0000) begin
                failures++;
                $display("FAIL post_reset_idle k=%0d fout=%b tick=%b exp=0000/0000", k, dif.fout, dif.tick);
            end
            checks++;
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        dif.divn     = '0;
        dif.div_load = '0;
        dif.mute     = '0;
        #2;
        test_reset();
        test_div4();
        test_two_channels();
        test_change();
        test_back_to_back();
        test_mute();
        test_all_channels();
        test_idle_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fdiv_poly.md
FDIV_POLY -- requirements
Module: fdiv_poly

Interface
REQ-001 Parameter NCH, default 4: number of independent tone channels (1..16).
REQ-002 Parameter W, default 32: divisor and counter width in bits (2..32).
REQ-003 fin  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 divn  input  NCH*W  divisor bus; channel i uses bits [i*W+W-1 : i*W].
REQ-006 div_load  input  NCH  per-channel strobe; captures channel i's divn slice as pending divisor.
REQ-007 mute  input  NCH  per-channel output mute; counter keeps running.
REQ-008 fout  output  NCH  registered square-wave output per channel.
REQ-009 tick  output  NCH  registered one-cycle pulse per channel at each period wrap.
REQ-010 nactive  output  clog2(NCH+1)  count of fout bits currently high.

Function
REQ-011 Each channel SHALL hold W-bit registers cnt, act (active divisor), pend (pending divisor), a pending-valid flag pv, and the fout and tick bits.
REQ-012 Channel idle when act < 2; idle channel SHALL hold cnt = 1, drive fout = 0 and tick = 0; no clock passthrough.
REQ-013 Idle channel with pv = 1 SHALL load act <= pend, clear pv, cnt <= 1 on that edge.
REQ-014 Running channel (act >= 2): wrap = (cnt >= act); on wrap cnt <= 1, else cnt <= cnt + 1; arithmetic mod 2^W, no overflow because cnt never exceeds act.
REQ-015 On a running wrap with pv = 1, SHALL load act <= pend and clear pv; divisor change occurs only at period boundary (glitch-free).
REQ-016 div_load[i] SHALL set pend <= divn slice and pv <= 1; a later load before the boundary overwrites pend (last write wins).
REQ-017 div_load coincident with wrap: existing pend (if pv) applied to act; the new value stored in pend with pv = 1, applied at next boundary.
REQ-018 fout[i] <= (act >= 2) && (cnt > act>>1) && !mute[i], computed from pre-edge values; period = act cycles, high for act - floor(act/2) cycles, low for floor(act/2).
REQ-019 tick[i] <= 1 for exactly one cycle after an edge where wrap occurred with act >= 2; tick unaffected by mute.
REQ-020 mute[i] SHALL not alter cnt, act, pend or pv; unmute resumes at current phase.
REQ-021 nactive SHALL equal the population count of fout, combinational from the fout registers.
REQ-022 Channels SHALL be fully independent; no cross-channel timing dependence.

Reset
REQ-023 reset = 1 at an edge SHALL set per channel cnt = 1, act = 0, pend = 0, pv = 0, fout = 0, tick = 0; nactive = 0 thereafter.
REQ-024 reset SHALL dominate div_load and wrap in the same cycle; a load presented during reset is discarded.
REQ-025 Reset mid-period SHALL abandon the period; channel stays idle until a new div_load.

Verification
REQ-026 Reset, then div_load[0] with divn0 = 4 -> from second edge after load fout[0] repeats 0,0,1,1 (period 4); tick[0] one pulse per 4 cycles; nactive toggles 0/1.
REQ-027 Channel 1 divn = 5 -> fout[1] high 3 cycles, low 2 cycles, period 5; channels 0 and 1 simultaneously unaffected by each other.
REQ-028 Channel 0 running at 4, load 8 mid-period -> current 4-cycle period completes unchanged, next period 8 cycles (4 low, 4 high); loads 6 then 10 within one period -> 10 applied.
REQ-029 Load coincident with wrap while pv = 1 (pend = 6, new 12) -> next period 6, following period 12.
REQ-030 mute[0] asserted 3 cycles mid-high phase -> fout[0] = 0 those cycles (one-cycle registered lag), tick[0] cadence unchanged, phase continuous on unmute.
REQ-031 divn = 1 or 0 loaded -> fout = 0, tick = 0 permanently; reset asserted mid-period at divisor 8 -> all outputs 0 next cycle, stays idle.
